mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
// Parametrised MEM pipeline stage between EX and WB. Issues loads/stores to an
// external data memory over a req/gnt/rvalid handshake with variable latency.
// Supports byte/half/word (and dword when DATA_W=64) accesses with byte enables,
// load sign/zero extension and misalignment detection. Stalls EX via ex_ready_o.
// PARAMETERS
// DATA_W    32  data path width; 32 or 64 only
// ADDR_W    32  byte address width
// MAX_WAIT  15  cycles allowed in REQ or RESP before bus-error completion (>=1)
// PORTS
// clk           in   1       clock, rising edge
// rst_n         in   1       async reset, active low
// ex_valid_i    in   1       EX presents an instruction
// ex_ready_o    out  1       stage accepts this cycle (valid&ready = accept)
// ex_type_i     in   3       definitions_pkg type code (LOAD, STORE, others)
// ex_size_i     in   2       0=byte 1=half 2=word 3=dword
// ex_unsigned_i in   1       1=zero-extend load data, 0=sign-extend
// ex_ir_i       in   32      instruction word, passed through
// ex_aluout_i   in   ADDR_W  effective address / ALU result
// ex_b_i        in   DATA_W  store data, LSB-aligned
// halted_i      in   1       pipeline halted: accept nothing new
// mem_req_o     out  1       memory request
// mem_we_o      out  1       1=write
// mem_addr_o    out  ADDR_W  address, aligned down to DATA_W/8 bytes
// mem_be_o      out  DATA_W/8 byte enables
// mem_wdata_o   out  DATA_W  store data shifted to byte lane
// mem_gnt_i     in   1       request accepted this cycle
// mem_rvalid_i  in   1       read data valid
// mem_rdata_i   in   DATA_W  read data
// wb_valid_o    out  1       one-cycle pulse, result for WB
// wb_type_o     out  3       registered ex_type_i
// wb_ir_o       out  32      registered ex_ir_i
// wb_aluout_o   out  ADDR_W  registered ex_aluout_i
// wb_lmd_o      out  DATA_W  extended load data; 0 for non-loads/errors
// wb_err_o      out  2       0=ok 1=misaligned 2=bus timeout (valid with wb_valid_o)
// BEHAVIOUR
// - Reset (async, rst_n=0): FSM=IDLE; all wb_* and mem_* outputs 0; ex_ready_o 0
//   during reset, 1 in IDLE after release. Timeout counter 0.
// - FSM: IDLE, REQ, RESP. ex_ready_o=1 only in IDLE and !halted_i.
// - IDLE accept, non-memory type: next cycle wb_valid_o=1, lmd=0, err=0 (latency 1).
// - IDLE accept, LOAD/STORE: off=addr mod DATA_W/8. Misaligned if off not multiple
//   of size bytes, or size=3 with DATA_W=32: no request, next cycle wb_valid_o=1,
//   err=1, lmd=0. Otherwise register request, go REQ.
// - REQ: mem_req_o=1 and req fields held stable until mem_gnt_i. On gnt: STORE ->
//   next cycle wb_valid_o=1, IDLE; LOAD -> RESP. mem_req_o drops the cycle after gnt.
// - RESP: on mem_rvalid_i (may equal gnt cycle+1 earliest), lane=rdata>>(8*off),
//   truncated to size, sign/zero extended to DATA_W; next cycle wb_valid_o=1, IDLE.
//   rvalid outside RESP is ignored.
// - mem_be_o: ((1<<(1<<size))-1)<<off; mem_wdata_o = ex_b_i<<(8*off).
// - Timeout: counter clears on REQ/RESP entry, increments each waiting cycle; at
//   MAX_WAIT -> wb_valid_o=1, err=2, lmd=0, mem_req_o=0, IDLE. Late gnt/rvalid ignored.
// - halted_i blocks new accepts only; an in-flight access always completes.
// - Back-to-back: a new accept is possible in the cycle wb_valid_o pulses.
// - wb_type/ir/aluout captured at accept, held until next accept.
// - Reset mid-access aborts immediately; memory side must tolerate dropped req.
// TESTING
// - LOAD word 0x100, gnt immediate, rvalid 2 cycles later 0xDEADBEEF -> lmd
//   0xDEADBEEF, err 0, ex_ready_o low 3 cycles.
// - LOAD byte signed addr 0x103, rdata 0x80112233 -> be 4'b1000, lmd 0xFFFFFF80;
//   unsigned -> 0x00000080.
// - STORE half addr 0x102 data 0x0000ABCD -> be 4'b1100, wdata 0xABCD0000, we=1,
//   wb_valid_o cycle after gnt.
// - STORE word addr 0x101 -> no mem_req_o, wb_valid_o next cycle with err=1.
// - LOAD with gnt never asserted, MAX_WAIT=4 -> err=2 after 4 REQ cycles, req drops.
// - halted_i=1 while ex_valid_i=1 -> no accept; rst_n low mid-RESP -> all outputs 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// Purpose : MEM pipeline stage; issues loads/stores on a req/gnt/rvalid bus, extends load data, flags misalignment and bus timeouts.
// Latency : non-memory/misaligned 1 cycle; store 1 cycle after gnt; load 1 cycle after rvalid; timeout after MAX_WAIT waiting cycles.
// Backpressure: ex_ready_o only in IDLE with !halted_i; an in-flight access always runs to completion.
//
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   ex_*                       instruction from EX (valid/ready handshake)
//   halted_i                   blocks new accepts
//   mem_*                      data memory request (req/gnt) and response (rvalid/rdata)
//   wb_*                       one-cycle result pulse towards WB with captured EX fields
module mem_access_stage #(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 32,
    parameter int          MAX_WAIT   = 15,
    parameter logic [2:0]  TYPE_LOAD  = 3'd1,
    parameter logic [2:0]  TYPE_STORE = 3'd2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [2:0]            ex_type_i,
    input  logic [1:0]            ex_size_i,
    input  logic                  ex_unsigned_i,
    input  logic [31:0]           ex_ir_i,
    input  logic [ADDR_W-1:0]     ex_aluout_i,
    input  logic [DATA_W-1:0]     ex_b_i,
    input  logic                  halted_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  wb_valid_o,
    output logic [2:0]            wb_type_o,
    output logic [31:0]           wb_ir_o,
    output logic [ADDR_W-1:0]     wb_aluout_o,
    output logic [DATA_W-1:0]     wb_lmd_o,
    output logic [1:0]            wb_err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_run;      // low only until the first edge after reset release
    logic [CNT_W-1:0]   r_cnt;
    logic [OFF_W-1:0]   r_off;
    logic [1:0]         r_size;
    logic               r_uns;

    logic               w_accept;
    logic               w_is_load;
    logic               w_is_store;
    logic [OFF_W-1:0]   w_off;
    logic [OFF_W-1:0]   w_mask;
    logic               w_misalign;
    logic [BE_W-1:0]    w_be_base;
    logic [BE_W-1:0]    w_be;
    logic [DATA_W-1:0]  w_wdata;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_lane;
    logic [DATA_W-1:0]  w_ext;

    // Kept low during reset and its release cycle so EX cannot hand over work
    // while the stage is still coming out of reset.
    assign ex_ready_o = r_run && (r_state == S_IDLE) && !halted_i;
    assign w_accept   = ex_valid_i && ex_ready_o;
    assign w_is_load  = (ex_type_i == TYPE_LOAD);
    assign w_is_store = (ex_type_i == TYPE_STORE);

    assign w_off   = ex_aluout_i[OFF_W-1:0];
    assign w_addr  = {ex_aluout_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_be    = w_be_base << w_off;
    assign w_wdata = ex_b_i << {w_off, 3'b000};

    always_comb begin
        w_be_base = '0;
        w_mask    = '0;
        case (ex_size_i)
            2'd0: begin w_be_base = BE_W'(1);      w_mask = OFF_W'(0); end
            2'd1: begin w_be_base = BE_W'(2'h3);   w_mask = OFF_W'(1); end
            2'd2: begin w_be_base = BE_W'(4'hF);   w_mask = OFF_W'(3); end
            default: begin w_be_base = BE_W'(8'hFF); w_mask = OFF_W'(7); end
        endcase
    end

    // A dword on a 32-bit path can never be served, so it is reported as misaligned.
    assign w_misalign = (|(w_off & w_mask)) || ((ex_size_i == 2'd3) && (DATA_W == 32));

    // Load data: move the addressed lane down to bit 0, then truncate and extend.
    assign w_lane = mem_rdata_i >> {r_off, 3'b000};

    always_comb begin
        w_ext = '0;
        case (r_size)
            2'd0:    w_ext = r_uns ? DATA_W'(w_lane[7:0])  : DATA_W'($signed(w_lane[7:0]));
            2'd1:    w_ext = r_uns ? DATA_W'(w_lane[15:0]) : DATA_W'($signed(w_lane[15:0]));
            2'd2:    w_ext = r_uns ? DATA_W'(w_lane[31:0]) : DATA_W'($signed(w_lane[31:0]));
            default: w_ext = w_lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_run       <= 1'b0;
            r_cnt       <= '0;
            r_off       <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            wb_valid_o  <= 1'b0;
            wb_type_o   <= '0;
            wb_ir_o     <= '0;
            wb_aluout_o <= '0;
            wb_lmd_o    <= '0;
            wb_err_o    <= ERR_OK;
        end else begin
            r_run      <= 1'b1;
            wb_valid_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        wb_type_o   <= ex_type_i;
                        wb_ir_o     <= ex_ir_i;
                        wb_aluout_o <= ex_aluout_i;
                        if (!(w_is_load || w_is_store)) begin
                            wb_valid_o <= 1'b1;
                            wb_lmd_o   <= '0;
                            wb_err_o   <= ERR_OK;
                        end else if (w_misalign) begin
                            wb_valid_o <= 1'b1;
                            wb_lmd_o   <= '0;
                            wb_err_o   <= ERR_ALIGN;
                        end else begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= w_is_store;
                            mem_addr_o  <= w_addr;
                            mem_be_o    <= w_be;
                            mem_wdata_o <= w_wdata;
                            r_off       <= w_off;
                            r_size      <= ex_size_i;
                            r_uns       <= ex_unsigned_i;
                            r_cnt       <= '0;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // A grant on the final waiting cycle still wins over the timeout.
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        r_cnt     <= '0;
                        if (mem_we_o) begin
                            wb_valid_o <= 1'b1;
                            wb_lmd_o   <= '0;
                            wb_err_o   <= ERR_OK;
                            r_state    <= S_IDLE;
                        end else begin
                            r_state    <= S_RESP;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        mem_req_o  <= 1'b0;
                        wb_valid_o <= 1'b1;
                        wb_lmd_o   <= '0;
                        wb_err_o   <= ERR_TIMEOUT;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (mem_rvalid_i) begin
                        wb_valid_o <= 1'b1;
                        wb_lmd_o   <= w_ext;
                        wb_err_o   <= ERR_OK;
                        r_state    <= S_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        wb_valid_o <= 1'b1;
                        wb_lmd_o   <= '0;
                        wb_err_o   <= ERR_TIMEOUT;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Purpose : directed, table-driven bench for mem_access_stage (DATA_W=32, MAX_WAIT=4).
// Latency : fixed cycle sequences; memory responses are driven by hand per case.
// Backpressure: ex_ready_o sampled every cycle; halted_i exercised before and during an access.
module tb_mem_access_stage;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = 4;
    localparam logic [2:0] T_LD  = 3'd1;
    localparam logic [2:0] T_ST  = 3'd2;
    localparam logic [2:0] T_ALU = 3'd4;
    localparam logic [31:0] JUNK = 32'hA5A5A5A5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid_i;
    logic          ex_ready_o;
    logic [2:0]    ex_type_i;
    logic [1:0]    ex_size_i;
    logic          ex_unsigned_i;
    logic [31:0]   ex_ir_i;
    logic [AW-1:0] ex_aluout_i;
    logic [DW-1:0] ex_b_i;
    logic          halted_i;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW/8-1:0] mem_be_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          wb_valid_o;
    logic [2:0]    wb_type_o;
    logic [31:0]   wb_ir_o;
    logic [AW-1:0] wb_aluout_o;
    logic [DW-1:0] wb_lmd_o;
    logic [1:0]    wb_err_o;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW), .TYPE_LOAD(T_LD), .TYPE_STORE(T_ST)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_type_i(ex_type_i),
        .ex_size_i(ex_size_i), .ex_unsigned_i(ex_unsigned_i), .ex_ir_i(ex_ir_i),
        .ex_aluout_i(ex_aluout_i), .ex_b_i(ex_b_i), .halted_i(halted_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_type_o(wb_type_o), .wb_ir_o(wb_ir_o),
        .wb_aluout_o(wb_aluout_o), .wb_lmd_o(wb_lmd_o), .wb_err_o(wb_err_o)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  typ;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] b;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] lmd;
        logic [1:0]  err;
        int          busy;   // cycles ex_ready_o is low between accept and result
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [2:0] typ, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] b, input logic [31:0] ir);
        ex_valid_i    = 1'b1;
        ex_type_i     = typ;
        ex_size_i     = size;
        ex_unsigned_i = uns;
        ex_aluout_i   = addr;
        ex_b_i        = b;
        ex_ir_i       = ir;
    endtask

    // Accepts one vector, plays the memory (gnt in first REQ cycle, rvalid
    // two cycles after gnt) and checks the request and the WB result.
    task automatic run_vec(input vec_t v, input int idx);
        int busy;
        logic [31:0] ir;
        ir = 32'hC0DE0000 | 32'(idx);
        drive_ex(v.typ, v.size, v.uns, v.addr, v.b, ir);
        #1;
        chk($sformatf("v%0d ready", idx), 64'(ex_ready_o), 64'd1);
        tick();
        ex_valid_i = 1'b0;
        busy = 0;
        if (v.err == 2'd0 && (v.typ == T_LD || v.typ == T_ST)) begin
            chk($sformatf("v%0d req", idx), 64'(mem_req_o), 64'd1);
            chk($sformatf("v%0d we", idx), 64'(mem_we_o), 64'(v.typ == T_ST));
            chk($sformatf("v%0d addr", idx), 64'(mem_addr_o), 64'(v.addr & 32'hFFFFFFFC));
            chk($sformatf("v%0d be", idx), 64'(mem_be_o), 64'(v.be));
            if (v.typ == T_ST) chk($sformatf("v%0d wdata", idx), 64'(mem_wdata_o), 64'(v.wdata));
            if (!ex_ready_o) busy++;
            mem_gnt_i = 1'b1;
            tick();
            mem_gnt_i = 1'b0;
            if (v.typ == T_LD) begin
                chk($sformatf("v%0d req_drop", idx), 64'(mem_req_o), 64'd0);
                if (!ex_ready_o) busy++;
                tick();
                if (!ex_ready_o) busy++;
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = v.rdata;
                tick();
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = JUNK;
            end
        end else begin
            chk($sformatf("v%0d no_req", idx), 64'(mem_req_o), 64'd0);
        end
        chk($sformatf("v%0d wb_valid", idx), 64'(wb_valid_o), 64'd1);
        chk($sformatf("v%0d err", idx), 64'(wb_err_o), 64'(v.err));
        chk($sformatf("v%0d lmd", idx), 64'(wb_lmd_o), 64'(v.lmd));
        chk($sformatf("v%0d ir", idx), 64'(wb_ir_o), 64'(ir));
        chk($sformatf("v%0d type", idx), 64'(wb_type_o), 64'(v.typ));
        chk($sformatf("v%0d aluout", idx), 64'(wb_aluout_o), 64'(v.addr));
        chk($sformatf("v%0d busy", idx), 64'(busy), 64'(v.busy));
        chk($sformatf("v%0d ready_at_wb", idx), 64'(ex_ready_o), 64'd1);
        tick();
        chk($sformatf("v%0d pulse", idx), 64'(wb_valid_o), 64'd0);
    endtask

    initial begin
        //          typ    size  uns   addr        b             rdata         be     wdata         lmd           err  busy
        vecs[0]  = '{T_LD, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 4'hF, 32'h0,        32'hDEADBEEF, 2'd0, 3};
        vecs[1]  = '{T_LD, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80112233, 4'h8, 32'h0,        32'hFFFFFF80, 2'd0, 3};
        vecs[2]  = '{T_LD, 2'd0, 1'b1, 32'h103, 32'h0,        32'h80112233, 4'h8, 32'h0,        32'h00000080, 2'd0, 3};
        vecs[3]  = '{T_LD, 2'd1, 1'b0, 32'h102, 32'h0,        32'h80112233, 4'hC, 32'h0,        32'hFFFF8011, 2'd0, 3};
        vecs[4]  = '{T_LD, 2'd1, 1'b1, 32'h100, 32'h0,        32'h80112233, 4'h3, 32'h0,        32'h00002233, 2'd0, 3};
        vecs[5]  = '{T_LD, 2'd0, 1'b0, 32'h101, 32'h0,        32'h80112233, 4'h2, 32'h0,        32'h00000022, 2'd0, 3};
        vecs[6]  = '{T_LD, 2'd0, 1'b0, 32'h102, 32'h0,        32'h00FF0000, 4'h4, 32'h0,        32'hFFFFFFFF, 2'd0, 3};
        vecs[7]  = '{T_ST, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 32'h0,        4'hC, 32'hABCD0000, 32'h0,        2'd0, 1};
        vecs[8]  = '{T_ST, 2'd0, 1'b0, 32'h101, 32'h12345678, 32'h0,        4'h2, 32'h34567800, 32'h0,        2'd0, 1};
        vecs[9]  = '{T_ST, 2'd2, 1'b0, 32'h101, 32'h11223344, 32'h0,        4'h0, 32'h0,        32'h0,        2'd1, 0};
        vecs[10] = '{T_LD, 2'd1, 1'b0, 32'h101, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        2'd1, 0};
        vecs[11] = '{T_LD, 2'd3, 1'b0, 32'h100, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        2'd1, 0};
        vecs[12] = '{T_ALU, 2'd2, 1'b0, 32'h55,  32'h0,       32'h0,        4'h0, 32'h0,        32'h0,        2'd0, 0};

        rst_n = 1'b0; ex_valid_i = 1'b0; ex_type_i = '0; ex_size_i = '0; ex_unsigned_i = 1'b0;
        ex_ir_i = '0; ex_aluout_i = '0; ex_b_i = '0; halted_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = JUNK;

        // Reset state
        tick();
        chk("rst ready", 64'(ex_ready_o), 64'd0);
        chk("rst req", 64'(mem_req_o), 64'd0);
        chk("rst wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst be", 64'(mem_be_o), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst ready", 64'(ex_ready_o), 64'd1);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Timeout: load with no grant, MAX_WAIT=4 REQ cycles then err=2.
        drive_ex(T_LD, 2'd2, 1'b0, 32'h200, 32'h0, 32'h7);
        tick();
        ex_valid_i = 1'b0;
        for (int c = 0; c < MW; c++) begin
            chk($sformatf("to req c%0d", c), 64'(mem_req_o), 64'd1);
            chk($sformatf("to addr c%0d", c), 64'(mem_addr_o), 64'h200);
            chk($sformatf("to wbv c%0d", c), 64'(wb_valid_o), 64'd0);
            tick();
        end
        chk("to wb_valid", 64'(wb_valid_o), 64'd1);
        chk("to err", 64'(wb_err_o), 64'd2);
        chk("to lmd", 64'(wb_lmd_o), 64'd0);
        chk("to req_drop", 64'(mem_req_o), 64'd0);
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        chk("late gnt ignored wbv", 64'(wb_valid_o), 64'd0);
        chk("late gnt ignored req", 64'(mem_req_o), 64'd0);

        // halted_i blocks accept
        halted_i = 1'b1;
        drive_ex(T_LD, 2'd2, 1'b0, 32'h240, 32'h0, 32'h8);
        #1;
        chk("halt ready", 64'(ex_ready_o), 64'd0);
        tick();
        tick();
        chk("halt no req", 64'(mem_req_o), 64'd0);
        chk("halt no wb", 64'(wb_valid_o), 64'd0);
        ex_valid_i = 1'b0;
        halted_i = 1'b0;

        // Held request across gnt wait, rvalid during REQ ignored, earliest rvalid,
        // halted_i raised mid-access does not stop completion.
        drive_ex(T_LD, 2'd2, 1'b0, 32'h300, 32'h0, 32'h9);
        tick();
        ex_valid_i = 1'b0;
        halted_i = 1'b1;
        chk("hold req1", 64'(mem_req_o), 64'd1);
        tick();
        chk("hold req2", 64'(mem_req_o), 64'd1);
        chk("hold addr2", 64'(mem_addr_o), 64'h300);
        chk("hold be2", 64'(mem_be_o), 64'hF);
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11111111;
        tick();
        mem_gnt_i = 1'b0; mem_rdata_i = 32'h22222222;
        chk("early rv ignored", 64'(wb_valid_o), 64'd0);
        tick();
        mem_rvalid_i = 1'b0; mem_rdata_i = JUNK;
        chk("inflight wbv", 64'(wb_valid_o), 64'd1);
        chk("inflight lmd", 64'(wb_lmd_o), 64'h22222222);
        chk("inflight halted ready", 64'(ex_ready_o), 64'd0);
        halted_i = 1'b0;
        tick();

        // Back-to-back accept in the cycle wb_valid_o pulses.
        drive_ex(T_ALU, 2'd0, 1'b0, 32'h10, 32'h0, 32'h1);
        tick();
        chk("b2b wbv1", 64'(wb_valid_o), 64'd1);
        chk("b2b ir1", 64'(wb_ir_o), 64'h1);
        drive_ex(T_ALU, 2'd0, 1'b0, 32'h20, 32'h0, 32'h2);
        chk("b2b ready", 64'(ex_ready_o), 64'd1);
        tick();
        ex_valid_i = 1'b0;
        chk("b2b wbv2", 64'(wb_valid_o), 64'd1);
        chk("b2b ir2", 64'(wb_ir_o), 64'h2);
        chk("b2b alu2", 64'(wb_aluout_o), 64'h20);
        tick();
        chk("b2b hold ir", 64'(wb_ir_o), 64'h2);

        // Reset while waiting in RESP.
        drive_ex(T_LD, 2'd2, 1'b0, 32'h400, 32'h0, 32'hA);
        tick();
        ex_valid_i = 1'b0;
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid rst ready", 64'(ex_ready_o), 64'd0);
        chk("mid rst mem", 64'({mem_req_o, mem_we_o, mem_be_o}), 64'd0);
        chk("mid rst addr", 64'(mem_addr_o), 64'd0);
        chk("mid rst wb", 64'({wb_valid_o, wb_type_o, wb_err_o}), 64'd0);
        chk("mid rst ir", 64'(wb_ir_o), 64'd0);
        chk("mid rst aluout", 64'(wb_aluout_o), 64'd0);
        tick();
        rst_n = 1'b1;
        mem_rvalid_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        chk("after rst ready", 64'(ex_ready_o), 64'd1);
        chk("after rst no wb", 64'(wb_valid_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
